mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multi-cycle sequencer for the MIPS core. The core shares one ALU and one unified instruction/data memory port across all instruction phases. This block drives every datapath mux select and write enable, state by state. It holds across memory wait states using a req/ready handshake, retires one instruction per pass, and flags illegal opcodes, HALT and memory timeouts.

Parameters:
MEM_TIMEOUT, 255, max cycles waiting for mem_ready in a memory state before bus_err; 0 disables the timeout.
CNT_W, 8, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset)
opcode  in  6  Instruction[31:26] from the instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_write  out  1  write strobe, qualified by mem_req
iord  out  1  address mux: 0 = PC, 1 = ALUOut
ir_write  out  1  load the instruction register
reg_dst  out  1  write register: 0 = rt, 1 = rd
mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  ALU A: 0 = PC, 1 = register A
alu_src_b  out  2  ALU B: 00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2
alu_op  out  2  00 = add, 01 = sub, 10 = use funct
pc_src  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target {PC[31:28], imm26, 00}
pc_en  out  1  PC load enable
instr_done  out  1  one-cycle pulse when an instruction retires
illegal_op  out  1  one-cycle pulse on an unsupported opcode in DECODE
bus_err  out  1  sticky flag: memory timeout; cleared only by reset
halted  out  1  high while in HALT
state  out  4  current state encoding, for debug

Behaviour:
- Reset (asynchronous, reset = 0): state = FETCH, wait counter = 0, bus_err = 0. Outputs follow the FETCH decode as soon as reset releases; no instruction is in flight.
- Outputs are Moore decodes of state. Exception: pc_en and ir_write in FETCH are also gated by mem_ready. Every output not listed for a state is 0.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, HALT 12, ERR 13.
- FETCH: mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_src = 00. When mem_ready = 1: ir_write = 1, pc_en = 1, go to DECODE. Otherwise hold in FETCH.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut). Next state by opcode:
  - 000000 -> EXEC
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - 111111 -> HALT
  - anything else -> FETCH with illegal_op = 1 for this cycle; nothing retires.
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req = 1, iord = 1. On mem_ready go to MEMWB.
- MEMWB: reg_write = 1, reg_dst = 0, mem_to_reg = 1, instr_done = 1, then FETCH.
- MEMWR: mem_req = 1, mem_write = 1, iord = 1. On mem_ready: instr_done = 1, go to FETCH.
- EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10, then ALUWB.
- ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0, instr_done = 1, then FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_src = 01, pc_en = zero, instr_done = 1, then FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_op = 00, then ADDIWB.
- ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0, instr_done = 1, then FETCH.
- JUMP: pc_src = 10, pc_en = 1, instr_done = 1, then FETCH.
- HALT: halted = 1, all enables 0. Exits only via reset.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD and MEMWR, and whenever mem_ready = 1.
  - Increments each cycle spent in one of those states with mem_ready = 0.
  - If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT with mem_ready still 0: go to ERR and set bus_err.
  - ERR: all enables 0, sticky until reset.
  - mem_ready on the same cycle the counter hits the limit wins: normal transition, no error.
- Latency with zero-wait memory (mem_ready tied 1): R-type 4 cycles, lw 5, sw 4, beq 3, addi 4, j 3. Each memory state adds one cycle per wait cycle.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- Reset asserted mid-instruction: returns to FETCH immediately with no write enables asserted. A partial instruction never retires.

Test Plan:
- mem_ready = 1, program addi, add, sw, lw, beq(taken), j -> state sequences 0,1,9,10 / 0,1,6,7 / 0,1,2,5 / 0,1,2,3,4 / 0,1,8 / 0,1,11. Six instr_done pulses; pc_en high in the beq BRANCH cycle.
- beq with zero = 0 -> pc_en = 0 in BRANCH, instr_done = 1, next state FETCH.
- lw with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, mem_req steady at 1, reg_write asserted exactly once, in MEMWB.
- MEM_TIMEOUT = 4, mem_ready held 0 in FETCH -> ERR after 4 wait cycles, bus_err = 1 and held. Repeat with mem_ready rising on the 4th cycle -> DECODE, no error.
- opcode 010001 in DECODE -> illegal_op pulse, next FETCH, no instr_done. Opcode 111111 -> halted = 1 stays high, no mem_req for 50 cycles.
- reset driven low asynchronously mid-MEMWR -> state = 0 before the next clk edge, mem_write = 0, bus_err = 0.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Unified instruction/data memory port between the multi-cycle sequencer and memory.
// The sequencer is the master; memory answers with mem_ready when the access completes.
interface mips_multicycle_ctrl_if;
  logic mem_req;
  logic mem_write;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_write, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_write, input iord, output mem_ready);
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: drives datapath selects/enables per state and
// tracks memory waits with a timeout counter.
//
// state  | meaning
// FETCH  | read instruction at PC, PC += 4 on completion
// DECODE | branch target into ALUOut, dispatch on opcode
// MEMADR | base + imm address for lw/sw
// MEMRD  | data read at ALUOut
// MEMWB  | MDR into rt
// MEMWR  | store B at ALUOut
// EXEC   | R-type ALU op
// ALUWB  | ALUOut into rd
// BRANCH | compare, PC = ALUOut when zero
// ADDIEX | A + imm
// ADDIWB | ALUOut into rt
// JUMP   | PC = jump target
// HALT   | stopped until reset
// ERR    | memory timeout, stopped until reset
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_multicycle_ctrl_if.master mem,
  input  logic [5:0]            opcode,
  input  logic                  zero,
  output logic                  ir_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            alu_op,
  output logic [1:0]            pc_src,
  output logic                  pc_en,
  output logic                  instr_done,
  output logic                  illegal_op,
  output logic                  bus_err,
  output logic                  halted,
  output logic [3:0]            state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_HALT   = 4'd12, S_ERR    = 4'd13
  } state_t;

  localparam bit             TO_EN = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(MEM_TIMEOUT);

  state_t           state_r, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_state;
  logic             wait_hit;

  assign state = state_r;

  // The cycle that would make the count reach the limit is the last one allowed.
  always_comb begin
    mem_state = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
    wait_hit  = TO_EN && mem_state && !mem.mem_ready &&
                (({1'b0, wait_cnt} + (CNT_W+1)'(1)) == LIMIT);
  end

  always_comb begin
    state_nxt     = state_r;
    mem.mem_req   = 1'b0;
    mem.mem_write = 1'b0;
    mem.iord      = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    pc_en         = 1'b0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    halted        = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        alu_src_b   = 2'b01;
        if (mem.mem_ready) begin
          ir_write  = 1'b1;
          pc_en     = 1'b1;
          state_nxt = S_DECODE;
        end else if (wait_hit) begin
          state_nxt = S_ERR;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          6'b000000:            state_nxt = S_EXEC;
          6'b100011, 6'b101011: state_nxt = S_MEMADR;
          6'b000100:            state_nxt = S_BRANCH;
          6'b001000:            state_nxt = S_ADDIEX;
          6'b000010:            state_nxt = S_JUMP;
          6'b111111:            state_nxt = S_HALT;
          default: begin
            illegal_op = 1'b1;
            state_nxt  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_nxt = (opcode == 6'b101011) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
        if (mem.mem_ready)  state_nxt = S_MEMWB;
        else if (wait_hit) state_nxt = S_ERR;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEMWR: begin
        mem.mem_req   = 1'b1;
        mem.mem_write = 1'b1;
        mem.iord      = 1'b1;
        if (mem.mem_ready) begin
          instr_done = 1'b1;
          state_nxt  = S_FETCH;
        end else if (wait_hit) begin
          state_nxt = S_ERR;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_en      = zero;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_nxt = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_FETCH;
    endcase
  end

  // Any state change (including entry to a memory state) restarts the wait count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= S_FETCH;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      if (state_nxt == S_ERR)
        bus_err <= 1'b1;
      if (mem.mem_ready || !mem_state || (state_nxt != state_r))
        wait_cnt <= '0;
      else if (wait_cnt != {CNT_W{1'b1}})
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multi-cycle sequencer with a short memory timeout (4)
// so timeout and ready-wins-at-limit cases stay brief.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_HALT = 6'h3f;
  localparam logic [5:0] OP_BAD  = 6'h11;

  // {mem_req,mem_write,iord,ir_write, reg_dst,mem_to_reg,reg_write,
  //  alu_src_a,alu_src_b,alu_op,pc_src, pc_en,instr_done,illegal_op,halted}
  localparam logic [17:0] K_FETCH_R  = {4'b1001, 3'b000, 1'b0, 2'b01, 2'b00, 2'b00, 4'b1000};
  localparam logic [17:0] K_FETCH_W  = {4'b1000, 3'b000, 1'b0, 2'b01, 2'b00, 2'b00, 4'b0000};
  localparam logic [17:0] K_DECODE   = {4'b0000, 3'b000, 1'b0, 2'b11, 2'b00, 2'b00, 4'b0000};
  localparam logic [17:0] K_DEC_ILL  = {4'b0000, 3'b000, 1'b0, 2'b11, 2'b00, 2'b00, 4'b0010};
  localparam logic [17:0] K_MEMADR   = {4'b0000, 3'b000, 1'b1, 2'b10, 2'b00, 2'b00, 4'b0000};
  localparam logic [17:0] K_MEMRD    = {4'b1010, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0000};
  localparam logic [17:0] K_MEMWB    = {4'b0000, 3'b011, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0100};
  localparam logic [17:0] K_MEMWR_R  = {4'b1110, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0100};
  localparam logic [17:0] K_MEMWR_W  = {4'b1110, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0000};
  localparam logic [17:0] K_EXEC     = {4'b0000, 3'b000, 1'b1, 2'b00, 2'b10, 2'b00, 4'b0000};
  localparam logic [17:0] K_ALUWB    = {4'b0000, 3'b101, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0100};
  localparam logic [17:0] K_BR_T     = {4'b0000, 3'b000, 1'b1, 2'b00, 2'b01, 2'b01, 4'b1100};
  localparam logic [17:0] K_BR_NT    = {4'b0000, 3'b000, 1'b1, 2'b00, 2'b01, 2'b01, 4'b0100};
  localparam logic [17:0] K_ADDIEX   = {4'b0000, 3'b000, 1'b1, 2'b10, 2'b00, 2'b00, 4'b0000};
  localparam logic [17:0] K_ADDIWB   = {4'b0000, 3'b001, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0100};
  localparam logic [17:0] K_JUMP     = {4'b0000, 3'b000, 1'b0, 2'b00, 2'b00, 2'b10, 4'b1100};
  localparam logic [17:0] K_HALT     = {4'b0000, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0001};
  localparam logic [17:0] K_IDLE     = 18'd0;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       pc_en, instr_done, illegal_op, bus_err, halted;
  logic [3:0] state;
  logic [17:0] ctrl;
  logic       exp_be;
  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;
  int         rw_cnt = 0;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem        (bus),
    .opcode     (opcode),
    .zero       (zero),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .pc_en      (pc_en),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .bus_err    (bus_err),
    .halted     (halted),
    .state      (state)
  );

  always #5 clk = ~clk;

  assign ctrl = {bus.mem_req, bus.mem_write, bus.iord, ir_write, reg_dst, mem_to_reg, reg_write,
                 alu_src_a, alu_src_b, alu_op, pc_src, pc_en, instr_done, illegal_op, halted};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Entered at a falling edge: apply inputs, check this cycle, move to the next falling edge.
  task automatic cyc(input string tag, input logic [5:0] op, input logic rdy, input logic z,
                     input logic [3:0] exp_st, input logic [17:0] exp_c);
    opcode = op;
    bus.mem_ready = rdy;
    zero = z;
    #1;
    chk({tag, " state"}, 32'(state), 32'(exp_st));
    chk({tag, " ctrl"}, 32'(ctrl), 32'(exp_c));
    chk({tag, " bus_err"}, 32'(bus_err), 32'(exp_be));
    if (instr_done === 1'b1) done_cnt++;
    if (reg_write === 1'b1) rw_cnt++;
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    exp_be = 1'b0;
    #1;
    chk({tag, " rst state"}, 32'(state), 32'd0);
    chk({tag, " rst bus_err"}, 32'(bus_err), 32'd0);
    chk({tag, " rst ctrl"}, 32'(ctrl), 32'(K_FETCH_W));
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    opcode = OP_R;
    zero = 1'b0;
    bus.mem_ready = 1'b0;
    exp_be = 1'b0;
    @(negedge clk);
    do_reset("init");

    // zero-wait program: addi, add, sw, lw, beq taken, j
    cyc("addi f", OP_ADDI, 1'b1, 1'b0, 4'd0,  K_FETCH_R);
    cyc("addi d", OP_ADDI, 1'b1, 1'b0, 4'd1,  K_DECODE);
    cyc("addi x", OP_ADDI, 1'b1, 1'b0, 4'd9,  K_ADDIEX);
    cyc("addi w", OP_ADDI, 1'b1, 1'b0, 4'd10, K_ADDIWB);
    cyc("add f",  OP_R,    1'b1, 1'b0, 4'd0,  K_FETCH_R);
    cyc("add d",  OP_R,    1'b1, 1'b0, 4'd1,  K_DECODE);
    cyc("add x",  OP_R,    1'b1, 1'b0, 4'd6,  K_EXEC);
    cyc("add w",  OP_R,    1'b1, 1'b0, 4'd7,  K_ALUWB);
    cyc("sw f",   OP_SW,   1'b1, 1'b0, 4'd0,  K_FETCH_R);
    cyc("sw d",   OP_SW,   1'b1, 1'b0, 4'd1,  K_DECODE);
    cyc("sw a",   OP_SW,   1'b1, 1'b0, 4'd2,  K_MEMADR);
    cyc("sw m",   OP_SW,   1'b1, 1'b0, 4'd5,  K_MEMWR_R);
    cyc("lw f",   OP_LW,   1'b1, 1'b0, 4'd0,  K_FETCH_R);
    cyc("lw d",   OP_LW,   1'b1, 1'b0, 4'd1,  K_DECODE);
    cyc("lw a",   OP_LW,   1'b1, 1'b0, 4'd2,  K_MEMADR);
    cyc("lw m",   OP_LW,   1'b1, 1'b0, 4'd3,  K_MEMRD);
    cyc("lw w",   OP_LW,   1'b1, 1'b0, 4'd4,  K_MEMWB);
    cyc("beq f",  OP_BEQ,  1'b1, 1'b1, 4'd0,  K_FETCH_R);
    cyc("beq d",  OP_BEQ,  1'b1, 1'b1, 4'd1,  K_DECODE);
    cyc("beq b",  OP_BEQ,  1'b1, 1'b1, 4'd8,  K_BR_T);
    cyc("j f",    OP_J,    1'b1, 1'b0, 4'd0,  K_FETCH_R);
    cyc("j d",    OP_J,    1'b1, 1'b0, 4'd1,  K_DECODE);
    cyc("j j",    OP_J,    1'b1, 1'b0, 4'd11, K_JUMP);
    chk("six retires", 32'(done_cnt), 32'd6);

    // beq not taken
    cyc("bnt f",  OP_BEQ,  1'b1, 1'b0, 4'd0,  K_FETCH_R);
    cyc("bnt d",  OP_BEQ,  1'b1, 1'b0, 4'd1,  K_DECODE);
    cyc("bnt b",  OP_BEQ,  1'b1, 1'b0, 4'd8,  K_BR_NT);
    chk("bnt retire", 32'(done_cnt), 32'd7);

    // lw with three wait cycles; ready arrives exactly at the timeout boundary
    rw_cnt = 0;
    cyc("lww f",  OP_LW,   1'b1, 1'b0, 4'd0,  K_FETCH_R);
    cyc("lww d",  OP_LW,   1'b1, 1'b0, 4'd1,  K_DECODE);
    cyc("lww a",  OP_LW,   1'b1, 1'b0, 4'd2,  K_MEMADR);
    for (int i = 0; i < 3; i++)
      cyc("lww wait", OP_LW, 1'b0, 1'b0, 4'd3, K_MEMRD);
    cyc("lww rdy", OP_LW,  1'b1, 1'b0, 4'd3,  K_MEMRD);
    cyc("lww wb",  OP_LW,  1'b1, 1'b0, 4'd4,  K_MEMWB);
    cyc("lww nx",  OP_LW,  1'b0, 1'b0, 4'd0,  K_FETCH_W);
    chk("lww reg_write once", 32'(rw_cnt), 32'd1);

    // fetch timeout: four waits then ERR, sticky
    do_reset("to");
    for (int i = 0; i < 4; i++)
      cyc("to wait", OP_R, 1'b0, 1'b0, 4'd0, K_FETCH_W);
    exp_be = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc("to err", OP_R, 1'b1, 1'b0, 4'd13, K_IDLE);

    // ready on the fourth wait cycle wins; then an illegal opcode
    do_reset("edge");
    for (int i = 0; i < 3; i++)
      cyc("edge wait", OP_BAD, 1'b0, 1'b0, 4'd0, K_FETCH_W);
    cyc("edge rdy", OP_BAD, 1'b1, 1'b0, 4'd0, K_FETCH_R);
    done_cnt = 0;
    cyc("ill d",  OP_BAD,  1'b1, 1'b0, 4'd1,  K_DEC_ILL);
    cyc("hlt f",  OP_HALT, 1'b1, 1'b0, 4'd0,  K_FETCH_R);
    chk("ill no retire", 32'(done_cnt), 32'd0);
    cyc("hlt d",  OP_HALT, 1'b1, 1'b0, 4'd1,  K_DECODE);
    for (int i = 0; i < 50; i++)
      cyc("halt", OP_HALT, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 4'd12, K_HALT);
    chk("halt no retire", 32'(done_cnt), 32'd0);

    // async reset in the middle of a waiting store
    do_reset("mid");
    cyc("mid f",  OP_SW,   1'b1, 1'b0, 4'd0,  K_FETCH_R);
    cyc("mid d",  OP_SW,   1'b1, 1'b0, 4'd1,  K_DECODE);
    cyc("mid a",  OP_SW,   1'b1, 1'b0, 4'd2,  K_MEMADR);
    cyc("mid w",  OP_SW,   1'b0, 1'b0, 4'd5,  K_MEMWR_W);
    #2;
    reset = 1'b0;
    #1;
    chk("mid rst state", 32'(state), 32'd0);
    chk("mid rst mem_write", 32'(bus.mem_write), 32'd0);
    chk("mid rst bus_err", 32'(bus_err), 32'd0);
    chk("mid rst ctrl", 32'(ctrl), 32'(K_FETCH_W));
    chk("mid no retire", 32'(done_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
